// File: rtl/csr_access_unit.sv
// ---------------------------------------------------------------------------
// csr_access_unit
// Sequencing front end for the CSR file. It takes one CSRRW/CSRRS/CSRRC
// request at a time and runs a probe (read) cycle on the shared CSR bus.
// When the access is legal and writes, one write cycle carrying set/clear
// masks follows. The pre-write value and an illegal flag are then returned
// on a valid/ready response channel.
//
// Optional feature macro: CSR_RO_CHECK_EN
//   defined   : a writing request to addr[11:10] == 2'b11 is flagged illegal
//               and the write cycle is skipped.
//   undefined : legality depends only on ack and a non-reserved op.
//
// Ports
//   clk_i, rst_i        clock, asynchronous active-low reset
//   req_*               request channel from execute (valid/ready)
//   csr_en_o/addr_o     CSR bus enable and address
//   csr_set_o/clear_o   write masks, non-zero only in the write cycle
//   csr_ack_i/rdata_i   OR-combined acknowledge and read data
//   rsp_*               response channel to the pipeline (valid/ready)
// ---------------------------------------------------------------------------
module csr_access_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [1:0]      req_op_i,
    input  logic [11:0]     req_addr_i,
    input  logic [XLEN-1:0] req_wdata_i,
    input  logic            req_nowrite_i,
    output logic            csr_en_o,
    output logic [11:0]     csr_addr_o,
    output logic [XLEN-1:0] csr_set_o,
    output logic [XLEN-1:0] csr_clear_o,
    input  logic            csr_ack_i,
    input  logic [XLEN-1:0] csr_rdata_i,
    output logic            rsp_valid_o,
    output logic [XLEN-1:0] rsp_rdata_o,
    output logic            rsp_illegal_o,
    input  logic            rsp_ready_i
);

    localparam int unsigned AW = 12;
    localparam logic [1:0] OP_RW = 2'b01;
    localparam logic [1:0] OP_RS = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_e;

    state_e          state_q;
    logic            req_ready_q;
    logic            csr_en_q;
    logic [AW-1:0]   csr_addr_q;
    logic [XLEN-1:0] csr_set_q;
    logic [XLEN-1:0] csr_clear_q;
    logic            rsp_valid_q;
    logic [XLEN-1:0] rsp_rdata_q;
    logic            rsp_illegal_q;
    logic [1:0]      op_q;
    logic [XLEN-1:0] wdata_q;
    logic            nowrite_q;

    logic            ro_hit_c;
    logic            illegal_c;

    // Read-only window check; the latched bus address doubles as the request address.
`ifdef CSR_RO_CHECK_EN
    assign ro_hit_c = (op_q != 2'b00) && !nowrite_q && (csr_addr_q[AW-1:AW-2] == 2'b11);
`else
    assign ro_hit_c = 1'b0;
`endif

    // Evaluated during the probe cycle only.
    assign illegal_c = !csr_ack_i || (op_q == 2'b00) || ro_hit_c;

    // Sequencer: state plus every registered output.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q       <= IDLE;
            req_ready_q   <= 1'b1;
            csr_en_q      <= 1'b0;
            csr_addr_q    <= '0;
            csr_set_q     <= '0;
            csr_clear_q   <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_illegal_q <= 1'b0;
            op_q          <= 2'b00;
            wdata_q       <= '0;
            nowrite_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid_i) begin
                        op_q        <= req_op_i;
                        wdata_q     <= req_wdata_i;
                        nowrite_q   <= req_nowrite_i;
                        csr_addr_q  <= req_addr_i;
                        csr_en_q    <= 1'b1;
                        req_ready_q <= 1'b0;
                        state_q     <= READ;
                    end
                end
                READ: begin
                    rsp_illegal_q <= illegal_c;
                    rsp_rdata_q   <= illegal_c ? '0 : csr_rdata_i;
                    if (illegal_c || nowrite_q) begin
                        csr_en_q    <= 1'b0;
                        csr_addr_q  <= '0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end else begin
                        state_q <= WRITE;
                        // Reserved op never reaches here, so the fall-through is RC.
                        case (op_q)
                            OP_RW: begin
                                csr_set_q   <= wdata_q;
                                csr_clear_q <= ~wdata_q;
                            end
                            OP_RS: begin
                                csr_set_q   <= wdata_q;
                                csr_clear_q <= '0;
                            end
                            default: begin
                                csr_set_q   <= '0;
                                csr_clear_q <= wdata_q;
                            end
                        endcase
                    end
                end
                WRITE: begin
                    csr_en_q    <= 1'b0;
                    csr_addr_q  <= '0;
                    csr_set_q   <= '0;
                    csr_clear_q <= '0;
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign req_ready_o   = req_ready_q;
    assign csr_en_o      = csr_en_q;
    assign csr_addr_o    = csr_addr_q;
    assign csr_set_o     = csr_set_q;
    assign csr_clear_o   = csr_clear_q;
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_rdata_o   = rsp_rdata_q;
    assign rsp_illegal_o = rsp_illegal_q;

endmodule

// File: tb/tb_csr_access_unit.sv
// ---------------------------------------------------------------------------
// tb_csr_access_unit
// Directed bench for csr_access_unit. The bench plays the CSR file: a
// writable register at 0x340 and a read-only register at 0xC00 (it ignores
// writes); every other address is unimplemented (no ack). A transaction-level
// model predicts, for each cycle after acceptance, what the bus and response
// outputs must be; a per-cycle compare checks the DUT against it. Literal
// expectations pin the model on key results.
// ---------------------------------------------------------------------------
module tb_csr_access_unit;

    localparam int unsigned XLEN = 32;

    logic            clk_i = 1'b0;
    logic            rst_i = 1'b1;
    logic            req_valid_i = 1'b0;
    logic            req_ready_o;
    logic [1:0]      req_op_i = 2'b00;
    logic [11:0]     req_addr_i = 12'h000;
    logic [XLEN-1:0] req_wdata_i = '0;
    logic            req_nowrite_i = 1'b0;
    logic            csr_en_o;
    logic [11:0]     csr_addr_o;
    logic [XLEN-1:0] csr_set_o;
    logic [XLEN-1:0] csr_clear_o;
    logic            csr_ack_i;
    logic [XLEN-1:0] csr_rdata_i;
    logic            rsp_valid_o;
    logic [XLEN-1:0] rsp_rdata_o;
    logic            rsp_illegal_o;
    logic            rsp_ready_i = 1'b0;

    csr_access_unit #(.XLEN(XLEN)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .req_valid_i   (req_valid_i),
        .req_ready_o   (req_ready_o),
        .req_op_i      (req_op_i),
        .req_addr_i    (req_addr_i),
        .req_wdata_i   (req_wdata_i),
        .req_nowrite_i (req_nowrite_i),
        .csr_en_o      (csr_en_o),
        .csr_addr_o    (csr_addr_o),
        .csr_set_o     (csr_set_o),
        .csr_clear_o   (csr_clear_o),
        .csr_ack_i     (csr_ack_i),
        .csr_rdata_i   (csr_rdata_i),
        .rsp_valid_o   (rsp_valid_o),
        .rsp_rdata_o   (rsp_rdata_o),
        .rsp_illegal_o (rsp_illegal_o),
        .rsp_ready_i   (rsp_ready_i)
    );

    always #5 clk_i = ~clk_i;

    // ---------------- CSR file stand-in ----------------
    localparam logic [31:0] C00_VAL = 32'h0000ABCD;
    logic [31:0] r340 = 32'h0;

    assign csr_ack_i   = csr_en_o && ((csr_addr_o == 12'h340) || (csr_addr_o == 12'hC00));
    assign csr_rdata_i = !csr_ack_i ? 32'h0 :
                         (csr_addr_o == 12'h340) ? r340 : C00_VAL;

    always @(posedge clk_i) begin
        if (csr_en_o && (csr_addr_o == 12'h340))
            r340 <= (r340 & ~csr_clear_o) | csr_set_o;
    end

    // ---------------- transaction model ----------------
    bit          m_busy = 1'b0;
    int          m_k = 0;          // cycles since acceptance
    logic [1:0]  m_op;
    logic [11:0] m_addr;
    logic [31:0] m_wdata;
    bit          m_wr;             // a write cycle is expected
    bit          m_ill;
    logic [31:0] m_rdata;

    function automatic bit impl(input logic [11:0] a);
        return (a == 12'h340) || (a == 12'hC00);
    endfunction

    always @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            m_busy = 1'b0;
        end else if (!m_busy) begin
            if (req_valid_i) begin
                bit ro;
                m_op    = req_op_i;
                m_addr  = req_addr_i;
                m_wdata = req_wdata_i;
                ro = 1'b0;
`ifdef CSR_RO_CHECK_EN
                ro = (req_op_i != 2'b00) && !req_nowrite_i && (req_addr_i >= 12'hC00);
`endif
                m_ill   = !impl(req_addr_i) || (req_op_i == 2'b00) || ro;
                m_wr    = !m_ill && !req_nowrite_i;
                m_rdata = m_ill ? 32'h0 : ((req_addr_i == 12'h340) ? r340 : C00_VAL);
                m_k     = 1;
                m_busy  = 1'b1;
            end
        end else if ((m_k >= (m_wr ? 3 : 2)) && rsp_ready_i) begin
            m_busy = 1'b0;
        end else begin
            m_k = m_k + 1;
        end
    end

    // ---------------- checking ----------------
    int n_tests = 0;
    int n_fail  = 0;
    int mask_total = 0;            // cycles seen with any non-zero mask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_cycle();
        logic        e_ready, e_en, e_valid;
        logic [11:0] e_addr;
        logic [31:0] e_set, e_clr;
        e_ready = !m_busy;
        e_en = 1'b0; e_addr = 12'h0; e_set = 32'h0; e_clr = 32'h0; e_valid = 1'b0;
        if (m_busy) begin
            if (m_k == 1) begin
                e_en = 1'b1; e_addr = m_addr;
            end else if (m_k == 2 && m_wr) begin
                e_en = 1'b1; e_addr = m_addr;
                if (m_op == 2'b01)      begin e_set = m_wdata; e_clr = ~m_wdata; end
                else if (m_op == 2'b10) begin e_set = m_wdata; end
                else                    begin e_clr = m_wdata; end
            end
            if (m_k >= (m_wr ? 3 : 2)) e_valid = 1'b1;
        end
        chk("req_ready", 32'(req_ready_o), 32'(e_ready));
        chk("csr_en", 32'(csr_en_o), 32'(e_en));
        chk("csr_addr", 32'(csr_addr_o), 32'(e_addr));
        chk("csr_set", csr_set_o, e_set);
        chk("csr_clear", csr_clear_o, e_clr);
        chk("rsp_valid", 32'(rsp_valid_o), 32'(e_valid));
        if (e_valid) begin
            chk("rsp_rdata", rsp_rdata_o, m_rdata);
            chk("rsp_illegal", 32'(rsp_illegal_o), 32'(m_ill));
        end
        if (csr_set_o != 0 || csr_clear_o != 0) mask_total++;
    endtask

    // Advance to the next falling edge and check outputs there.
    task automatic tick();
        @(negedge clk_i);
        if (rst_i) compare_cycle();
    endtask

    logic [31:0] last_rdata;
    logic        last_ill;
    int          last_masks;

    task automatic do_txn(input logic [1:0] op, input logic [11:0] addr,
                          input logic [31:0] wd, input logic nw, input int hold);
        int m0;
        int i;
        m0 = mask_total;
        req_valid_i = 1'b1; req_op_i = op; req_addr_i = addr;
        req_wdata_i = wd; req_nowrite_i = nw;
        i = 0;
        while (!req_ready_o && i < 20) begin tick(); i++; end
        if (!req_ready_o) chk("accept_timeout", 32'(req_ready_o), 32'd1);
        tick();
        req_valid_i = 1'b0;
        i = 0;
        while (!rsp_valid_o && i < 20) begin tick(); i++; end
        if (!rsp_valid_o) chk("rsp_timeout", 32'(rsp_valid_o), 32'd1);
        last_rdata = rsp_rdata_o;
        last_ill   = rsp_illegal_o;
        for (int h = 0; h < hold; h++) tick();
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;
        last_masks = mask_total - m0;
    endtask

    initial begin
        #1 rst_i = 1'b0;
        repeat (2) @(negedge clk_i);
        chk("rst_req_ready", 32'(req_ready_o), 32'd1);
        chk("rst_csr_en", 32'(csr_en_o), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata_o, 32'h0);
        rst_i = 1'b1;
        tick();

        // Preload, then RW returning the old value.
        do_txn(2'b01, 12'h340, 32'h12345678, 1'b0, 0);
        do_txn(2'b01, 12'h340, 32'hDEADBEEF, 1'b0, 0);
        chk("rw_old", last_rdata, 32'h12345678);
        chk("rw_ill", 32'(last_ill), 32'd0);
        chk("rw_new", r340, 32'hDEADBEEF);

        // Set then clear.
        do_txn(2'b01, 12'h340, 32'hF0F0F0F0, 1'b0, 0);
        do_txn(2'b10, 12'h340, 32'h0000000F, 1'b0, 0);
        chk("rs_old", last_rdata, 32'hF0F0F0F0);
        chk("rs_new", r340, 32'hF0F0F0FF);
        do_txn(2'b11, 12'h340, 32'hF0000000, 1'b0, 0);
        chk("rc_new", r340, 32'h00F0F0FF);

        // Read-only style access: no write cycle.
        do_txn(2'b10, 12'h340, 32'h0, 1'b1, 0);
        chk("nw_rdata", last_rdata, 32'h00F0F0FF);
        chk("nw_masks", 32'(last_masks), 32'd0);
        chk("nw_value", r340, 32'h00F0F0FF);

        // Unimplemented address.
        do_txn(2'b01, 12'h7C0, 32'hFFFFFFFF, 1'b0, 0);
        chk("unimp_ill", 32'(last_ill), 32'd1);
        chk("unimp_rdata", last_rdata, 32'h0);
        chk("unimp_masks", 32'(last_masks), 32'd0);

        // Reserved op on an acked address.
        do_txn(2'b00, 12'h340, 32'h11111111, 1'b0, 0);
        chk("rsv_ill", 32'(last_ill), 32'd1);
        chk("rsv_rdata", last_rdata, 32'h0);
        chk("rsv_value", r340, 32'h00F0F0FF);

        // Read-only window, with 5 cycles of response backpressure.
        do_txn(2'b01, 12'hC00, 32'h00001234, 1'b0, 5);
`ifdef CSR_RO_CHECK_EN
        chk("ro_ill", 32'(last_ill), 32'd1);
        chk("ro_rdata", last_rdata, 32'h0);
        chk("ro_masks", 32'(last_masks), 32'd0);
`else
        chk("ro_ill", 32'(last_ill), 32'd0);
        chk("ro_rdata", last_rdata, 32'h0000ABCD);
        chk("ro_masks", 32'(last_masks), 32'd1);
`endif

        // Reset in the middle of a write cycle.
        req_valid_i = 1'b1; req_op_i = 2'b01; req_addr_i = 12'h340;
        req_wdata_i = 32'hAAAAAAAA; req_nowrite_i = 1'b0;
        tick();
        req_valid_i = 1'b0;
        tick();
        chk("wr_cycle_set", csr_set_o, 32'hAAAAAAAA);
        #2 rst_i = 1'b0;
        #1;
        chk("rstw_req_ready", 32'(req_ready_o), 32'd1);
        chk("rstw_csr_en", 32'(csr_en_o), 32'd0);
        chk("rstw_csr_addr", 32'(csr_addr_o), 32'd0);
        chk("rstw_set", csr_set_o, 32'h0);
        chk("rstw_clear", csr_clear_o, 32'h0);
        chk("rstw_rsp_valid", 32'(rsp_valid_o), 32'd0);
        chk("rstw_rsp_rdata", rsp_rdata_o, 32'h0);
        chk("rstw_rsp_ill", 32'(rsp_illegal_o), 32'd0);
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
        tick();
        chk("rstw_value", r340, 32'h00F0F0FF);

        do_txn(2'b10, 12'h340, 32'h0, 1'b1, 0);
        chk("post_rst_rdata", last_rdata, 32'h00F0F0FF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
